// File: rtl/obi_stall_pkg.sv
// obi_stall_pkg: shared types and constants for the OBI stall scheduler.
//   stall_mode_e  - stall source selection (off / fixed / random / reserved)
//   state_e       - grant FSM states
//   LFSR_TAPS     - Galois feedback polynomial of the random source
//   lfsr_next()   - one Galois LFSR step
package obi_stall_pkg;

    localparam int          DELAY_WL_DEFAULT = 4;
    localparam logic [15:0] LFSR_TAPS        = 16'hB400;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        FIXED  = 2'd1,
        RANDOM = 2'd2,
        RSVD   = 2'd3
    } stall_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        GRANT = 2'd2
    } state_e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/obi_stall_lfsr.sv
// obi_stall_lfsr: 16-bit Galois LFSR used as the stall random source.
// Ports:
//   clk_i   - clock
//   rst_ni  - synchronous active-low reset, loads SEED
//   en_i    - advance one step this cycle
//   lfsr_o  - current LFSR value
module obi_stall_lfsr
    import obi_stall_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    output logic [15:0] lfsr_o
);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lfsr_o <= SEED;
        end else if (en_i) begin
            lfsr_o <= lfsr_next(lfsr_o);
        end
    end

endmodule

// File: rtl/obi_stall_ctrl.sv
// obi_stall_ctrl: grant / response stall scheduler for the testbench OBI slave.
// Optional build macro: OBI_STALL_CTRL_STATS_EN enables the grant and
// stall-cycle statistics counters; otherwise those outputs are tied to 0.
// Ports:
//   clk_i, rst_ni      - clock, synchronous active-low reset
//   req_i, we_i        - OBI request / write enable from the master
//   gnt_o              - OBI grant (also pushes the response FIFO)
//   rvalid_i           - response retired by the FIFO
//   en_stall_i         - global stall enable
//   stall_mode_i       - 0 off, 1 fixed, 2 random, 3 reserved (off)
//   max_stall_i        - clamp for random stalls
//   gnt_stall_i        - fixed grant stall
//   valid_stall_i      - fixed valid stall
//   valid_stall_o      - valid stall of the granted transaction (when gnt_o)
//   outstanding_o      - granted-but-not-retired transaction count
//   err_o              - sticky protocol error
//   stat_gnt_cnt_o     - grant count
//   stat_stall_cyc_o   - cycles with req_i high and no grant
module obi_stall_ctrl
    import obi_stall_pkg::*;
#(
    parameter int          MAX_OUTSTANDING = 8,
    parameter int          DELAY_WL        = DELAY_WL_DEFAULT,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    localparam int         CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    input  logic                we_i,
    output logic                gnt_o,
    input  logic                rvalid_i,
    input  logic                en_stall_i,
    input  logic [1:0]          stall_mode_i,
    input  logic [DELAY_WL-1:0] max_stall_i,
    input  logic [DELAY_WL-1:0] gnt_stall_i,
    input  logic [DELAY_WL-1:0] valid_stall_i,
    output logic [DELAY_WL-1:0] valid_stall_o,
    output logic [CNT_W-1:0]    outstanding_o,
    output logic                err_o,
    output logic [31:0]         stat_gnt_cnt_o,
    output logic [31:0]         stat_stall_cyc_o
);

    state_e              state_q, state_d;
    logic [DELAY_WL-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]    outst_q;
    logic                err_q, err_set;
    logic [15:0]         lfsr;
    logic [DELAY_WL-1:0] gd, vd, lfsr_g, lfsr_v;
    logic                full, gnt, lfsr_en;

    // Advance on every IDLE cycle that sees a request and on every grant;
    // a zero-latency grant is both, but still a single step.
    assign lfsr_en = (state_q == IDLE && req_i) || gnt_o;

    obi_stall_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (lfsr_en),
        .lfsr_o (lfsr)
    );

    assign lfsr_g = lfsr[DELAY_WL-1:0];
    assign lfsr_v = lfsr[2*DELAY_WL-1:DELAY_WL];

    always_comb begin
        gd = '0;
        vd = '0;
        if (en_stall_i) begin
            case (stall_mode_e'(stall_mode_i))
                FIXED: begin
                    gd = gnt_stall_i;
                    vd = valid_stall_i;
                end
                RANDOM: begin
                    gd = (lfsr_g < max_stall_i) ? lfsr_g : max_stall_i;
                    vd = (lfsr_v < max_stall_i) ? lfsr_v : max_stall_i;
                end
                default: ;
            endcase
        end
    end

    assign full = (outst_q == CNT_W'(MAX_OUTSTANDING));

    // cnt holds the number of STALL cycles still to spend before GRANT, so
    // a grant stall of gd puts gnt_o exactly gd cycles after the request
    // (gd = 1 skips STALL entirely).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;
        err_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (gd == '0) begin
                        gnt = !full;
                    end else begin
                        cnt_d   = gd - 1'b1;
                        state_d = (gd == DELAY_WL'(1)) ? GRANT : STALL;
                    end
                end
            end
            STALL: begin
                if (!req_i) begin
                    state_d = IDLE;
                    err_set = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == DELAY_WL'(1)) state_d = GRANT;
                end
            end
            GRANT: begin
                if (!req_i) begin
                    state_d = IDLE;
                    err_set = 1'b1;
                end else if (!full) begin
                    gnt     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rvalid_i && outst_q == '0) err_set = 1'b1;
    end

    // Grant is combinational from req_i; mask it while reset is asserted.
    assign gnt_o         = gnt & rst_ni;
    assign valid_stall_o = gnt_o ? vd : '0;
    assign outstanding_o = outst_q;
    assign err_o         = err_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            outst_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_q | err_set;
            // No grant can happen while full, so +1 never overflows.
            case ({gnt_o, rvalid_i})
                2'b10:   outst_q <= outst_q + 1'b1;
                2'b01:   if (outst_q != '0) outst_q <= outst_q - 1'b1;
                default: ;
            endcase
        end
    end

`ifdef OBI_STALL_CTRL_STATS_EN
    logic [31:0] stat_gnt_q, stat_stall_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stat_gnt_q   <= '0;
            stat_stall_q <= '0;
        end else begin
            if (gnt_o)          stat_gnt_q   <= stat_gnt_q + 1'b1;
            if (req_i && !gnt_o) stat_stall_q <= stat_stall_q + 1'b1;
        end
    end

    assign stat_gnt_cnt_o   = stat_gnt_q;
    assign stat_stall_cyc_o = stat_stall_q;
`else
    assign stat_gnt_cnt_o   = '0;
    assign stat_stall_cyc_o = '0;
`endif

    // we_i only matters to the surrounding memory model; upper LFSR bits are
    // not used for the default stall width.
    logic unused_sink;
    assign unused_sink = ^{we_i, lfsr};

endmodule

// File: tb/tb_obi_stall_ctrl.sv
module tb_obi_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we, gnt, rvalid, en_stall;
    logic [1:0]  mode;
    logic [3:0]  max_stall, gnt_stall, valid_stall, vstall;
    logic [3:0]  outst;
    logic        err;
    logic [31:0] stat_gnt, stat_stall;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    obi_stall_ctrl dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_i            (req),
        .we_i             (we),
        .gnt_o            (gnt),
        .rvalid_i         (rvalid),
        .en_stall_i       (en_stall),
        .stall_mode_i     (mode),
        .max_stall_i      (max_stall),
        .gnt_stall_i      (gnt_stall),
        .valid_stall_i    (valid_stall),
        .valid_stall_o    (vstall),
        .outstanding_o    (outst),
        .err_o            (err),
        .stat_gnt_cnt_o   (stat_gnt),
        .stat_stall_cyc_o (stat_stall)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic int mn(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Entered and left at posedge+1. Holds req until grant (bounded), then
    // retires the response with one rvalid pulse. lat = -1 on timeout.
    task automatic txn(input logic wr, output int lat, output int vs);
        lat = -1;
        vs  = -1;
        req = 1'b1;
        we  = wr;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (gnt) begin
                lat = c;
                vs  = int'(vstall);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        req    = 1'b0;
        we     = 1'b0;
        rvalid = 1'b1;
        @(posedge clk); #1;
        rvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        req    = 1'b0;
        rvalid = 1'b0;
        we     = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       en;
        logic [1:0] md;
        logic [3:0] gs;
        logic [3:0] vs;
        logic       wr;
        int         exp_lat;
        int         exp_vs;
    } vec_t;

    vec_t vecs[9];
    int   lat, vsv;
    int   gaps[100];
    int   lat1[100];
    int   vs11[100];

    initial begin
        vecs[0] = '{1'b1, 2'd0, 4'd5,  4'd5,  1'b0, 0,  0};
        vecs[1] = '{1'b1, 2'd1, 4'd3,  4'd5,  1'b0, 3,  5};
        vecs[2] = '{1'b1, 2'd1, 4'd0,  4'd7,  1'b0, 0,  7};
        vecs[3] = '{1'b1, 2'd1, 4'd1,  4'd0,  1'b0, 1,  0};
        vecs[4] = '{1'b1, 2'd1, 4'd15, 4'd15, 1'b0, 15, 15};
        vecs[5] = '{1'b1, 2'd3, 4'd4,  4'd4,  1'b0, 0,  0};
        vecs[6] = '{1'b0, 2'd1, 4'd4,  4'd6,  1'b0, 0,  0};
        vecs[7] = '{1'b1, 2'd1, 4'd2,  4'd9,  1'b1, 2,  9};
        vecs[8] = '{1'b1, 2'd1, 4'd6,  4'd1,  1'b1, 6,  1};

        en_stall = 1'b0; mode = 2'd0; max_stall = '0;
        gnt_stall = '0; valid_stall = '0;
        rst_n = 1'b0; req = 1'b1; rvalid = 1'b0; we = 1'b0;

        // reset state, request held high during reset must not be granted
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_vstall", int'(vstall), 0);
        chk("rst_outst", int'(outst), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_stat_gnt", int'(stat_gnt), 0);
        chk("rst_stat_stall", int'(stat_stall), 0);
        @(posedge clk); #1;
        req = 1'b0;
        rst_n = 1'b1;

        // table-driven single transactions
        foreach (vecs[i]) begin
            en_stall = vecs[i].en; mode = vecs[i].md;
            gnt_stall = vecs[i].gs; valid_stall = vecs[i].vs;
            txn(vecs[i].wr, lat, vsv);
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d_vstall", i), vsv, vecs[i].exp_vs);
        end
        @(negedge clk);
        chk("vec_outst_end", int'(outst), 0);
        chk("vec_err_end", int'(err), 0);
        @(posedge clk); #1;

        // mode 0, back-to-back requests with responses retiring
        en_stall = 1'b1; mode = 2'd0;
        req = 1'b1;
        for (int c = 0; c < 10; c++) begin
            rvalid = (c >= 1);
            @(negedge clk);
            chk($sformatf("b2b_gnt%0d", c), int'(gnt), 1);
            chk($sformatf("b2b_vs%0d", c), int'(vstall), 0);
            chk($sformatf("b2b_outst_le1_%0d", c), int'(outst <= 1), 1);
            @(posedge clk); #1;
        end
        req = 1'b0; rvalid = 1'b1;
        @(posedge clk); #1;
        rvalid = 1'b0;
        @(negedge clk);
        chk("b2b_outst_end", int'(outst), 0);
        chk("b2b_err", int'(err), 0);

        // fill to MAX_OUTSTANDING, then check back-pressure
        do_reset();
        en_stall = 1'b1; mode = 2'd0;
        req = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("fill_gnt%0d", c), int'(gnt), 1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("full_outst", int'(outst), 8);
        chk("full_gnt", int'(gnt), 0);
        @(posedge clk); #1;
        rvalid = 1'b1;
        @(negedge clk);
        chk("full_rv_gnt", int'(gnt), 0);
        @(posedge clk); #1;
        rvalid = 1'b0;
        @(negedge clk);
        chk("after_rv_outst", int'(outst), 7);
        chk("after_rv_gnt", int'(gnt), 1);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        chk("refill_outst", int'(outst), 8);
        chk("full_err", int'(err), 0);

        // req dropped during stall -> sticky error, FSM back to IDLE
        do_reset();
        en_stall = 1'b1; mode = 2'd1; gnt_stall = 4'd4; valid_stall = 4'd3;
        req = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("drop_err_before", int'(err), 0);
        chk("drop_gnt_s1", int'(gnt), 0);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        chk("drop_err_pending", int'(err), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("drop_err_set", int'(err), 1);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("drop_err_sticky", int'(err), 1);
        @(posedge clk); #1;
        gnt_stall = 4'd0;
        txn(1'b0, lat, vsv);
        chk("drop_idle_lat", lat, 0);
        chk("drop_idle_vs", vsv, 3);
        @(negedge clk);
        chk("drop_err_still", int'(err), 1);
        @(posedge clk); #1;
        do_reset();
        @(negedge clk);
        chk("rv_err_clear", int'(err), 0);
        @(posedge clk); #1;
        rvalid = 1'b1;
        @(posedge clk); #1;
        rvalid = 1'b0;
        @(negedge clk);
        chk("rv_underflow_err", int'(err), 1);
        chk("rv_underflow_outst", int'(outst), 0);
        @(posedge clk); #1;

        // random mode vs model, then replay after reset
        for (int run = 0; run < 2; run++) begin
            logic [15:0] m;
            int g, v;
            do_reset();
            en_stall = 1'b1; mode = 2'd2; max_stall = 4'd2;
            m = 16'hACE1;
            for (int i = 0; i < 100; i++) begin
                if (run == 0) gaps[i] = $urandom_range(0, 2);
                repeat (gaps[i]) begin
                    @(posedge clk); #1;
                end
                g = mn(int'(m[3:0]), 2);
                if (g == 0) begin
                    v = mn(int'(m[7:4]), 2);
                    m = step(m);
                end else begin
                    m = step(m);
                    v = mn(int'(m[7:4]), 2);
                    m = step(m);
                end
                txn(1'($urandom_range(0, 1)), lat, vsv);
                if (run == 0) begin
                    chk($sformatf("rnd%0d_lat", i), lat, g);
                    chk($sformatf("rnd%0d_vs", i), vsv, v);
                    chk($sformatf("rnd%0d_bound", i), int'(lat <= 2 && vsv <= 2), 1);
                    lat1[i] = lat;
                    vs11[i] = vsv;
                end else begin
                    chk($sformatf("rep%0d_lat", i), lat, lat1[i]);
                    chk($sformatf("rep%0d_vs", i), vsv, vs11[i]);
                end
            end
        end
        @(negedge clk);
        chk("rnd_err", int'(err), 0);
        @(posedge clk); #1;

        // statistics, then reset mid-stall
        do_reset();
        en_stall = 1'b1; mode = 2'd1; gnt_stall = 4'd2; valid_stall = 4'd0;
        for (int i = 0; i < 3; i++) begin
            txn(1'b0, lat, vsv);
            chk($sformatf("stat_txn%0d_lat", i), lat, 2);
        end
        @(negedge clk);
`ifdef OBI_STALL_CTRL_STATS_EN
        chk("stat_gnt", int'(stat_gnt), 3);
        chk("stat_stall", int'(stat_stall), 6);
`else
        chk("stat_gnt_tied", int'(stat_gnt), 0);
        chk("stat_stall_tied", int'(stat_stall), 0);
`endif
        @(posedge clk); #1;
        gnt_stall = 4'd4;
        req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_gnt", int'(gnt), 0);
        chk("midrst_stat_gnt", int'(stat_gnt), 0);
        chk("midrst_stat_stall", int'(stat_stall), 0);
        chk("midrst_outst", int'(outst), 0);
        @(posedge clk); #1;
        req = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        // abandoned request must not resurface as a late grant
        gnt_stall = 4'd0; valid_stall = 4'd8;
        txn(1'b0, lat, vsv);
        chk("postrst_lat", lat, 0);
        chk("postrst_vs", vsv, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
